// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// with imem/dmem ready handshakes, illegal-opcode trap and retire counter.
//
// Ports: clk, rst (sync, active-high); inst (IR); BrEq/BrLt (comparator);
// imem_ready/dmem_ready in, imem_req/dmem_req out; IRWrite, PCWrite, PCSel,
// Imm_Sel, regWEn, BrUn, Asel, Bsel, MemRW, ALU_sel, WBSel, load_type
// (datapath controls); state, illegal, instret (status).
module multicycle_control_unit #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             BrEq,
  input  logic             BrLt,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSel,
  output logic [2:0]       Imm_Sel,
  output logic             regWEn,
  output logic             BrUn,
  output logic             Asel,
  output logic             Bsel,
  output logic             MemRW,
  output logic [3:0]       ALU_sel,
  output logic [1:0]       WBSel,
  output logic [2:0]       load_type,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_SLL  = 4'd2;
  localparam logic [3:0] A_SLT  = 4'd3;
  localparam logic [3:0] A_SLTU = 4'd4;
  localparam logic [3:0] A_XOR  = 4'd5;
  localparam logic [3:0] A_SRL  = 4'd6;
  localparam logic [3:0] A_SRA  = 4'd7;
  localparam logic [3:0] A_OR   = 4'd8;
  localparam logic [3:0] A_AND  = 4'd9;
  localparam logic [3:0] A_PASS = 4'd10;

  state_t state_q, state_d;
  logic   retire;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       b30;
  logic       rd_nz;
  logic       unused_bits;

  assign opc         = inst[6:0];
  assign f3          = inst[14:12];
  assign b30         = inst[30];
  assign rd_nz       = |inst[11:7];
  assign unused_bits = ^{inst[31], inst[29:15]};

  logic is_r, is_i, is_lui, is_aui, is_ld, is_st, is_br, is_jal, is_jr;
  logic legal, is_jump;

  assign is_r    = opc == OP_R;
  assign is_i    = opc == OP_I;
  assign is_lui  = opc == OP_LUI;
  assign is_aui  = opc == OP_AUI;
  assign is_ld   = opc == OP_LD;
  assign is_st   = opc == OP_ST;
  assign is_br   = opc == OP_BR;
  assign is_jal  = opc == OP_JAL;
  assign is_jr   = opc == OP_JR;
  assign is_jump = is_jal | is_jr;
  assign legal   = is_r | is_i | is_lui | is_aui | is_ld |
                   is_st | is_br | is_jump;

  logic imem_ok, dmem_ok;
  assign imem_ok = MEM_WAIT_EN ? imem_ready : 1'b1;
  assign dmem_ok = MEM_WAIT_EN ? dmem_ready : 1'b1;

  // ADDI has no SUB form, so bit 30 only flips ADD for R-type.
  logic [3:0] alu_fn;
  always_comb begin
    alu_fn = A_ADD;
    unique case (f3)
      3'd0: alu_fn = (is_r && b30) ? A_SUB : A_ADD;
      3'd1: alu_fn = A_SLL;
      3'd2: alu_fn = A_SLT;
      3'd3: alu_fn = A_SLTU;
      3'd4: alu_fn = A_XOR;
      3'd5: alu_fn = b30 ? A_SRA : A_SRL;
      3'd6: alu_fn = A_OR;
      3'd7: alu_fn = A_AND;
      default: alu_fn = A_ADD;
    endcase
  end

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0:       taken = BrEq;
      3'd1:       taken = !BrEq;
      3'd4, 3'd6: taken = BrLt;
      3'd5, 3'd7: taken = !BrLt;
      default:    taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSel     = 1'b0;
    Imm_Sel   = 3'd0;
    regWEn    = 1'b0;
    BrUn      = 1'b0;
    Asel      = 1'b0;
    Bsel      = 1'b0;
    MemRW     = 1'b0;
    ALU_sel   = A_ADD;
    WBSel     = 2'd0;
    illegal   = 1'b0;
    load_type = f3;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ok) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (legal || !TRAP_EN) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_r, is_i: begin
            ALU_sel = alu_fn;
            Bsel    = is_i;
            state_d = S_WB;
          end
          is_lui: begin
            ALU_sel = A_PASS;
            Bsel    = 1'b1;
            Imm_Sel = 3'd3;
            state_d = S_WB;
          end
          is_aui: begin
            Asel    = 1'b1;
            Bsel    = 1'b1;
            Imm_Sel = 3'd3;
            state_d = S_WB;
          end
          is_ld, is_st: begin
            Bsel    = 1'b1;
            Imm_Sel = is_st ? 3'd1 : 3'd0;
            state_d = S_MEM;
          end
          is_br: begin
            Asel    = 1'b1;
            Bsel    = 1'b1;
            Imm_Sel = 3'd2;
            BrUn    = f3[1];
            PCWrite = 1'b1;
            PCSel   = taken;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          is_jump: begin
            Asel    = is_jal;
            Bsel    = 1'b1;
            Imm_Sel = is_jal ? 3'd4 : 3'd0;
            state_d = S_WB;
          end
          default: begin
            // Unknown opcode without trapping: step PC as a NOP.
            PCWrite = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemRW    = is_st;
        if (dmem_ok) begin
          if (is_st) begin
            PCWrite = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        regWEn  = rd_nz;
        PCWrite = 1'b1;
        PCSel   = is_jump;
        WBSel   = is_ld ? 2'd0 : (is_jump ? 2'd2 : 2'd1);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset squashes every control so a half-done instruction has no effect.
    if (rst) begin
      retire    = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSel     = 1'b0;
      Imm_Sel   = 3'd0;
      regWEn    = 1'b0;
      BrUn      = 1'b0;
      Asel      = 1'b0;
      Bsel      = 1'b0;
      MemRW     = 1'b0;
      ALU_sel   = A_ADD;
      WBSel     = 2'd0;
      illegal   = 1'b0;
      load_type = 3'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control vectors
// queued as expectations and compared at the falling edge.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0] st;
    logic       ireq;
    logic       dreq;
    logic       irw;
    logic       pcw;
    logic       pcs;
    logic [2:0] imm;
    logic       rwe;
    logic       brun;
    logic       asel;
    logic       bsel;
    logic       mrw;
    logic [3:0] alu;
    logic [1:0] wbs;
    logic       ill;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        BrEq, BrLt, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, IRWrite, PCWrite, PCSel;
  logic [2:0]  Imm_Sel;
  logic        regWEn, BrUn, Asel, Bsel, MemRW;
  logic [3:0]  ALU_sel;
  logic [1:0]  WBSel;
  logic [2:0]  load_type;
  logic [2:0]  state;
  logic        illegal;
  logic [7:0]  instret;

  multicycle_control_unit #(
    .MEM_WAIT_EN(1'b1),
    .CNT_W(8),
    .TRAP_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .inst(inst),
    .BrEq(BrEq), .BrLt(BrLt),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel),
    .Imm_Sel(Imm_Sel), .regWEn(regWEn), .BrUn(BrUn),
    .Asel(Asel), .Bsel(Bsel), .MemRW(MemRW),
    .ALU_sel(ALU_sel), .WBSel(WBSel), .load_type(load_type),
    .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  ctl_t obs;
  assign obs = {state, imem_req, dmem_req, IRWrite, PCWrite, PCSel,
                Imm_Sel, regWEn, BrUn, Asel, Bsel, MemRW,
                ALU_sel, WBSel, illegal};

  ctl_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic cyc(input string tag, input ctl_t e);
    ctl_t want;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic ctl_t mk(input logic [2:0] st);
    mk    = '0;
    mk.st = st;
  endfunction

  function automatic ctl_t fetch_ok();
    fetch_ok      = mk(3'd0);
    fetch_ok.ireq = 1'b1;
    fetch_ok.irw  = 1'b1;
  endfunction

  function automatic ctl_t wb(input logic rwe, input logic [1:0] wbs,
                              input logic pcs);
    wb     = mk(3'd4);
    wb.pcw = 1'b1;
    wb.rwe = rwe;
    wb.wbs = wbs;
    wb.pcs = pcs;
  endfunction

  task automatic run_alu(input string tag, input logic [31:0] ins,
                         input logic [3:0] alu, input logic bsel);
    ctl_t e;
    inst = ins;
    cyc({tag, "_F"}, fetch_ok());
    cyc({tag, "_D"}, mk(3'd1));
    e      = mk(3'd2);
    e.alu  = alu;
    e.bsel = bsel;
    cyc({tag, "_E"}, e);
    cyc({tag, "_W"}, wb(1'b1, 2'd1, 1'b0));
  endtask

  task automatic run_br(input string tag, input logic [31:0] ins,
                        input logic brun, input logic pcs);
    ctl_t e;
    inst = ins;
    cyc({tag, "_F"}, fetch_ok());
    cyc({tag, "_D"}, mk(3'd1));
    e      = mk(3'd2);
    e.asel = 1'b1;
    e.bsel = 1'b1;
    e.imm  = 3'd2;
    e.brun = brun;
    e.pcw  = 1'b1;
    e.pcs  = pcs;
    cyc({tag, "_E"}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t e;
    rst        = 1'b1;
    inst       = 32'h0000_0013;
    BrEq       = 1'b0;
    BrLt       = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_idle", mk(3'd0));
    chk("reset_instret", 32'(instret), 0);
    rst = 1'b0;

    run_alu("add", 32'h0020_8233, 4'd0, 1'b0);
    chk("add_instret", 32'(instret), 1);

    inst       = 32'h4020_81B3;
    imem_ready = 1'b0;
    e          = mk(3'd0);
    e.ireq     = 1'b1;
    cyc("sub_Fstall", e);
    imem_ready = 1'b1;
    run_alu("sub", 32'h4020_81B3, 4'd1, 1'b0);
    chk("sub_instret", 32'(instret), 2);

    run_alu("srai", 32'h4030_D293, 4'd7, 1'b1);
    run_alu("addi_b30", 32'h4000_8293, 4'd0, 1'b1);
    chk("addi_instret", 32'(instret), 4);

    inst = 32'h0040_A403;
    cyc("lw_F", fetch_ok());
    cyc("lw_D", mk(3'd1));
    e      = mk(3'd2);
    e.bsel = 1'b1;
    cyc("lw_E", e);
    dmem_ready = 1'b0;
    e      = mk(3'd3);
    e.dreq = 1'b1;
    cyc("lw_M0", e);
    cyc("lw_M1", e);
    dmem_ready = 1'b1;
    cyc("lw_M2", e);
    chk("lw_ltype", 32'(load_type), 2);
    cyc("lw_W", wb(1'b1, 2'd0, 1'b0));
    chk("lw_instret", 32'(instret), 5);

    BrEq = 1'b1;
    BrLt = 1'b0;
    run_br("beq", 32'h0072_8663, 1'b0, 1'b1);
    run_br("bne", 32'h0062_9663, 1'b0, 1'b0);
    BrLt = 1'b1;
    run_br("bltu", 32'h0092_E663, 1'b1, 1'b1);
    chk("br_instret", 32'(instret), 8);

    inst = 32'h00C0_00EF;
    cyc("jal_F", fetch_ok());
    cyc("jal_D", mk(3'd1));
    e      = mk(3'd2);
    e.asel = 1'b1;
    e.bsel = 1'b1;
    e.imm  = 3'd4;
    cyc("jal_E", e);
    cyc("jal_W", wb(1'b1, 2'd2, 1'b1));

    inst = 32'h0004_0067;
    cyc("jalr_F", fetch_ok());
    cyc("jalr_D", mk(3'd1));
    e      = mk(3'd2);
    e.bsel = 1'b1;
    cyc("jalr_E", e);
    cyc("jalr_W", wb(1'b0, 2'd2, 1'b1));
    chk("jmp_instret", 32'(instret), 10);

    inst = 32'h0030_A223;
    cyc("sw_F", fetch_ok());
    cyc("sw_D", mk(3'd1));
    e      = mk(3'd2);
    e.bsel = 1'b1;
    e.imm  = 3'd1;
    cyc("sw_E", e);
    rst = 1'b1;
    cyc("sw_M_rst", mk(3'd3));
    rst = 1'b0;
    chk("sw_rst_instret", 32'(instret), 0);

    inst = 32'hFFFF_FFFF;
    cyc("ill_F", fetch_ok());
    cyc("ill_D", mk(3'd1));
    e     = mk(3'd5);
    e.ill = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ill_TRAP", e);
    chk("ill_instret", 32'(instret), 0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    inst = 32'h0072_8663;
    for (int i = 0; i < 255; i++) begin
      repeat (3) @(posedge clk);
      #1;
    end
    chk("wrap_pre", 32'(instret), 255);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_zero", 32'(instret), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
